// File: rtl/dds_update_sequencer_if.sv
// Host/DDS-side signal bundle for the IO_UPDATE trigger sequencer.
// The master drives the burst controls and the DROVER line; the slave is the sequencer.
`timescale 1ns/1ps
interface dds_update_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] upd_width_ns;
  logic [WIDTH-1:0] period_ns;
  logic [WIDTH-1:0] burst_num;
  logic             drover;
  logic             io_update;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] chirp_cnt;
  logic             ramp_err;

  modport master (
    output start, stop, upd_width_ns, period_ns, burst_num, drover,
    input  io_update, busy, done, chirp_cnt, ramp_err
  );

  modport slave (
    input  start, stop, upd_width_ns, period_ns, burst_num, drover,
    output io_update, busy, done, chirp_cnt, ramp_err
  );
endinterface

// File: rtl/dds_update_sequencer.sv
// AD9910 IO_UPDATE burst generator with DROVER supervision: programmable width,
// period and pulse count; flags any ramp still running at the end of its period.
//
// state | meaning
// IDLE  | waiting for an accepted start
// PULSE | io_update high for W cycles
// WAIT  | io_update low until the period ends; DROVER sampled on the last cycle
// DONE  | one-cycle done pulse after a finite burst
`timescale 1ns/1ps
module dds_update_sequencer #(
  parameter int CLKNUM = 2,
  parameter int WIDTH  = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  dds_update_sequencer_if.slave     bus
);

  localparam int SH = $clog2(CLKNUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_burst;
  logic [WIDTH-1:0] r_chirp;
  logic [WIDTH-1:0] w_chirp_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_latch;
  logic             r_drv_s1;
  logic             r_drv_s2;
  logic             r_io;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_w_raw;
  logic [WIDTH-1:0] w_w_new;
  logic [WIDTH-1:0] w_p_raw;
  logic [WIDTH-1:0] w_p_new;

  // ns to cycles; guarantee at least one high and one low cycle per period
  always_comb begin
    w_w_raw = bus.upd_width_ns >> SH;
    w_w_new = (w_w_raw == '0) ? WIDTH'(1) : w_w_raw;
    w_p_raw = bus.period_ns >> SH;
    w_p_new = (w_p_raw <= w_w_new) ? (w_w_new + WIDTH'(1)) : w_p_raw;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_chirp_nxt = r_chirp;
    w_err_nxt   = r_err;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          w_latch     = 1'b1;
          w_state_nxt = PULSE;
          w_cnt_nxt   = '0;
          w_chirp_nxt = WIDTH'(1);
          w_err_nxt   = 1'b0;
        end
      end
      PULSE: begin
        if (bus.stop) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
          if (r_cnt == r_w - WIDTH'(1)) begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.stop) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == r_p - WIDTH'(1)) begin
          w_cnt_nxt = '0;
          if (!r_drv_s2) begin
            w_err_nxt = 1'b1;
          end
          if ((r_burst == '0) || (r_chirp < r_burst)) begin
            w_state_nxt = PULSE;
            w_chirp_nxt = r_chirp + WIDTH'(1);
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt    <= '0;
      r_w      <= WIDTH'(1);
      r_p      <= WIDTH'(2);
      r_burst  <= '0;
      r_chirp  <= '0;
      r_err    <= 1'b0;
      r_drv_s1 <= 1'b0;
      r_drv_s2 <= 1'b0;
      r_io     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_chirp  <= w_chirp_nxt;
      r_err    <= w_err_nxt;
      r_drv_s1 <= bus.drover;
      r_drv_s2 <= r_drv_s1;
      r_io     <= (w_state_nxt == PULSE);
      r_busy   <= (w_state_nxt == PULSE) || (w_state_nxt == WAIT);
      r_done   <= (w_state_nxt == DONE);
      if (w_latch) begin
        r_w     <= w_w_new;
        r_p     <= w_p_new;
        r_burst <= bus.burst_num;
      end
    end
  end

  assign bus.io_update = r_io;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.chirp_cnt = r_chirp;
  assign bus.ramp_err  = r_err;

endmodule

// File: tb/tb_dds_update_sequencer.sv
// Directed bench for dds_update_sequencer: cycle-by-cycle pulse train, done,
// busy, ramp_err and chirp_cnt against hand-derived W/P/N timing.
`timescale 1ns/1ps
module tb_dds_update_sequencer;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;

  dds_update_sequencer_if #(.WIDTH(16)) bus ();

  dds_update_sequencer #(.CLKNUM(2), .WIDTH(16)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  always #1 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // advance to the next rising edge, then step into the quiet part of the cycle
  task automatic tick();
    @(posedge sys_clk);
    #0.5;
  endtask

  // i counts cycles from t0 (first io_update-high cycle).
  // W/P/N are hand-derived cycle counts; -1 disables stop/drover-low/err/restart events.
  task automatic run(input int w_ns, input int p_ns, input int n_set,
                     input int W, input int P, input int N,
                     input int stop_at, input int lo_from, input int lo_to,
                     input int err_at, input int restart_at, input int ncyc,
                     input int exp_chirp, input string name);
    bit stopped, active, e_io, e_done, e_err;
    bus.upd_width_ns = 16'(w_ns);
    bus.period_ns    = 16'(p_ns);
    bus.burst_num    = 16'(n_set);
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.upd_width_ns = 16'd200;
    bus.period_ns    = 16'd6;
    bus.burst_num    = 16'd7;
    for (int i = 0; i < ncyc; i++) begin
      stopped = (stop_at >= 0) && (i > stop_at);
      active  = !stopped && ((N == 0) || (i < N * P));
      e_io    = active && ((i % P) < W);
      e_done  = (stop_at < 0) && (N != 0) && (i == N * P);
      e_err   = (err_at >= 0) && (i >= err_at);
      chk($sformatf("%s io@%0d", name, i), 32'(bus.io_update), 32'(e_io));
      chk($sformatf("%s busy@%0d", name, i), 32'(bus.busy), 32'(active));
      chk($sformatf("%s done@%0d", name, i), 32'(bus.done), 32'(e_done));
      chk($sformatf("%s err@%0d", name, i), 32'(bus.ramp_err), 32'(e_err));
      bus.drover = (i >= lo_from && i < lo_to) ? 1'b0 : 1'b1;
      bus.stop   = (i == stop_at);
      bus.start  = (i == restart_at);
      tick();
      bus.stop   = 1'b0;
      bus.start  = 1'b0;
    end
    bus.drover = 1'b1;
    chk($sformatf("%s chirp_cnt", name), 32'(bus.chirp_cnt), 32'(exp_chirp));
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.upd_width_ns = '0;
    bus.period_ns    = '0;
    bus.burst_num    = '0;
    bus.drover       = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    repeat (3) tick();

    chk("rst io", 32'(bus.io_update), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst chirp", 32'(bus.chirp_cnt), 32'd0);
    chk("rst err", 32'(bus.ramp_err), 32'd0);

    // 8 ns / 40 ns -> W=4, P=20; done at t0+60 (s+61)
    run(8, 40, 3, 4, 20, 3, -1, -1, -1, -1, -1, 64, 3, "basic");
    // zero width and 2 ns period -> W=1, P=2; done at t0+8 (s+9)
    run(0, 2, 4, 1, 2, 4, -1, -1, -1, -1, -1, 12, 4, "min");
    // continuous burst, stop on the 3rd cycle of the 6th pulse (t0+102)
    run(8, 40, 0, 4, 20, 0, 102, -1, -1, -1, -1, 110, 6, "stop");
    // DROVER low across the first period end -> ramp_err from t0+20, sticky
    run(8, 40, 2, 4, 20, 2, -1, 5, 25, 20, -1, 46, 2, "drover");
    // next accepted start clears ramp_err; a start during WAIT is ignored
    run(8, 40, 2, 4, 20, 2, -1, -1, -1, -1, 10, 44, 2, "restart");
    // period shorter than width is stretched to W+1: 12 ns/10 ns -> W=6, P=7
    run(12, 10, 2, 6, 7, 2, -1, -1, -1, -1, -1, 17, 2, "stretch");

    // start and stop together in IDLE: start is dropped
    bus.upd_width_ns = 16'd8;
    bus.period_ns    = 16'd40;
    bus.burst_num    = 16'd1;
    bus.start        = 1'b1;
    bus.stop         = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ss io@%0d", i), 32'(bus.io_update), 32'd0);
      chk($sformatf("ss busy@%0d", i), 32'(bus.busy), 32'd0);
      tick();
    end

    // asynchronous reset in the middle of the second pulse
    bus.burst_num = 16'd3;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (21) tick();
    chk("pre-rst io", 32'(bus.io_update), 32'd1);
    chk("pre-rst chirp", 32'(bus.chirp_cnt), 32'd2);
    #0.2;
    sys_rst = 1'b1;
    #0.1;
    chk("arst io", 32'(bus.io_update), 32'd0);
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst chirp", 32'(bus.chirp_cnt), 32'd0);
    chk("arst done", 32'(bus.done), 32'd0);
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    chk("post-rst io", 32'(bus.io_update), 32'd0);
    run(8, 40, 1, 4, 20, 1, -1, -1, -1, -1, -1, 24, 1, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", n_errs, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
